// File: rtl/gpb_audio_pkg.sv
// Shared audio types and constants for the effect chain.
// Samples are signed Q1.15; gain is unsigned 1.16 with unity at 2^16.
package gpb_audio_pkg;

  localparam int SAMPLE_W = 16;
  localparam int LFO_W    = 16;
  localparam int DEPTH_W  = 8;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic [LFO_W-1:0]           lfo_t;
  typedef logic [DEPTH_W-1:0]         depth_t;
  typedef logic [16:0]                gain_t;

  localparam gain_t GAIN_UNITY   = 17'h10000;
  localparam lfo_t  LFO_MAX      = '1;
  localparam int    TREM_LATENCY = 3;

endpackage

// File: rtl/tremolo_modulator_if.sv
// Sample stream handshakes plus the modulation controls feeding the tremolo.
// The slave modport is the tremolo's view; master is the surrounding chain.
interface tremolo_modulator_if;
  import gpb_audio_pkg::*;

  logic    in_valid;
  sample_t in_sample;
  logic    in_ready;
  logic    out_valid;
  sample_t out_sample;
  logic    out_ready;
  lfo_t    lfo_val;
  depth_t  depth;
  logic    enable;

  modport master (
    output in_valid, in_sample, out_ready, lfo_val, depth, enable,
    input  in_ready, out_valid, out_sample
  );

  modport slave (
    input  in_valid, in_sample, out_ready, lfo_val, depth, enable,
    output in_ready, out_valid, out_sample
  );

endinterface

// File: rtl/tremolo_gain_calc.sv
// Combinational tremolo gain: 1.0 - depth*(1 - lfo), in 1.16 fixed point.
// The trough with full depth still leaves 257/65536 of the signal.
module tremolo_gain_calc
  import gpb_audio_pkg::*;
(
  input  lfo_t   lfo,
  input  depth_t depth,
  input  logic   enable,
  output gain_t  gain
);

  logic [15:0] inv_next;
  logic [23:0] scaled_next;
  logic [15:0] red_next;

  always_comb begin
    inv_next    = LFO_MAX - lfo;
    scaled_next = {16'd0, depth} * {8'd0, inv_next};
    red_next    = 16'(scaled_next >> 8);
    gain        = enable ? (GAIN_UNITY - {1'b0, red_next}) : GAIN_UNITY;
  end

endmodule

// File: rtl/tremolo_modulator.sv
// Three-stage tremolo: capture, gain calculation, multiply with round-half-up.
// A held output (valid without ready) freezes every stage at once.
module tremolo_modulator
  import gpb_audio_pkg::*;
(
  input  logic CLK,
  input  logic RESET,
  tremolo_modulator_if.slave bus
);

  localparam logic signed [33:0] ROUND_HALF = 34'sd32768;

  logic    stall;

  logic    s1_valid_reg;
  sample_t s1_sample_reg;
  lfo_t    s1_lfo_reg;
  depth_t  s1_depth_reg;
  logic    s1_enable_reg;

  logic    s2_valid_reg;
  sample_t s2_sample_reg;
  gain_t   s2_gain_reg;

  logic    s3_valid_reg;
  sample_t s3_sample_reg;

  gain_t              gain_next;
  logic signed [33:0] prod_next;
  logic signed [33:0] rounded_next;
  sample_t            out_next;

  assign stall          = s3_valid_reg & ~bus.out_ready;
  assign bus.in_ready   = ~stall;
  assign bus.out_valid  = s3_valid_reg;
  assign bus.out_sample = s3_sample_reg;

  tremolo_gain_calc u_gain_calc (
    .lfo    (s1_lfo_reg),
    .depth  (s1_depth_reg),
    .enable (s1_enable_reg),
    .gain   (gain_next)
  );

  // Gain never exceeds unity, so the rounded product always fits a sample.
  always_comb begin
    prod_next    = 34'(s2_sample_reg) * 34'($signed({1'b0, s2_gain_reg}));
    rounded_next = prod_next + ROUND_HALF;
    out_next     = sample_t'(rounded_next >>> 16);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_valid_reg  <= 1'b0;
      s1_sample_reg <= '0;
      s1_lfo_reg    <= '0;
      s1_depth_reg  <= '0;
      s1_enable_reg <= 1'b0;
      s2_valid_reg  <= 1'b0;
      s2_sample_reg <= '0;
      s2_gain_reg   <= '0;
      s3_valid_reg  <= 1'b0;
      s3_sample_reg <= '0;
    end else if (!stall) begin
      s1_valid_reg <= bus.in_valid;
      // Modulation controls are frozen with the sample they belong to.
      if (bus.in_valid) begin
        s1_sample_reg <= bus.in_sample;
        s1_lfo_reg    <= bus.lfo_val;
        s1_depth_reg  <= bus.depth;
        s1_enable_reg <= bus.enable;
      end
      s2_valid_reg  <= s1_valid_reg;
      s2_sample_reg <= s1_sample_reg;
      s2_gain_reg   <= gain_next;
      s3_valid_reg  <= s2_valid_reg;
      s3_sample_reg <= out_next;
    end
  end

endmodule
